multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
Control FSM and condition unit that sequences a shared-memory multicycle ARM datapath.
- One ALU is time-shared for PC increment, address generation and data processing.
- Supports data-processing (DP), LDR/STR (immediate offset) and B.
- Holds the NZCV flags register, evaluates condition codes, and gates every architectural write.

Parameters:
- FLAG_RST, 4'b0000, reset value of the {N,Z,C,V} flags register.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- Instr  in  32  instruction register contents (valid from DECODE onward).
- ALUFlags  in  4  {N,Z,C,V} from ALU, current cycle.
- mem_ready  in  1  memory ready; only used with MC_MEM_WAIT_EN.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut.
- MemWrite  out  1  data memory write enable.
- IRWrite  out  1  instruction register enable.
- ResultSrc  out  2  result select: 00=ALUOut, 01=Data, 10=ALUResult.
- ALUSrcA  out  1  ALU A select: 0=reg A, 1=PC.
- ALUSrcB  out  2  ALU B select: 00=reg B, 01=ExtImm, 10=constant 4.
- RegSrc  out  2  register-address select, same encoding as the datapath ra1/ra2 muxes.
- ImmSrc  out  2  extend type: 00=DP imm8, 01=mem imm12, 10=branch imm24.
- RegWrite  out  1  register file write enable.
- ALUControl  out  4  operation: 0000 ADD, 0001 SUB, 0010 AND, 0011 ORR, 0100 EOR, 0101 pass B.
- Flags  out  4  registered NZCV.
- State  out  4  current FSM state, for debug.

Behaviour:
- Reset
  - State=FETCH; Flags=FLAG_RST.
  - While reset=1, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0.
  - Reset mid-instruction abandons it; no partial write occurs in the reset cycle.
- States (4-bit)
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9.
- Transitions
  - FETCH→DECODE.
  - DECODE: op=01→MEMADR; op=00, I=0→EXECR; op=00, I=1→EXECI; op=10→BRANCH; op=11→FETCH (no-op).
  - MEMADR: L=1→MEMRD, L=0→MEMWR.
  - MEMRD→MEMWB. MEMWB, MEMWR, ALUWB, BRANCH→FETCH.
  - EXECR/EXECI→ALUWB.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10, PCWrite=1.
- DECODE: ALUSrcA=1, ALUSrcB=10, ALUControl=ADD (produces PC+8), RegSrc per opcode.
- MEMADR: ALUSrcA=0, ALUSrcB=01, ImmSrc=01; ALUControl=ADD if U=1, SUB if U=0.
- MEMRD: AdrSrc=1.
- MEMWB: ResultSrc=01, RegWrite=CondEx.
- MEMWR: AdrSrc=1, MemWrite=CondEx.
- EXECR/EXECI:
  - ALUSrcA=0; ALUSrcB=00 (EXECR) or 01 (EXECI); ImmSrc=00; ALUControl decoded from cmd.
  - cmd decode: ADD 0100, SUB 0010, AND 0000, ORR 1100, EOR 0001, CMP 1010 (SUB), MOV 1101 (pass B).
  - Unlisted cmd: ALU operation is ADD and RegWrite is suppressed.
- ALUWB: ResultSrc=00, RegWrite=CondEx, except CMP, which never writes.
- BRANCH: ALUSrcA=1, ALUSrcB=01, ImmSrc=10, ALUControl=ADD, ResultSrc=10, PCWrite=CondEx.
- Rd=15 on MEMWB/ALUWB: PCWrite=CondEx in the same cycle, RegWrite=0.
- CondEx
  - Combinational from Instr[31:28] and the registered Flags.
  - All standard ARM codes EQ..AL are supported; 1111 evaluates false.
- Flags update
  - Occurs at the end of EXECR/EXECI only when S=1 (CMP always) and CondEx=1.
  - N,Z always update on those instructions; C,V update only for ADD/SUB/CMP.
- Cycle counts: B=3, DP=4, STR=4, LDR=5.
- A condition-failed instruction keeps its normal cycle count but performs no writes.

Optional Feature:
MC_MEM_WAIT_EN
- Defined:
  - FETCH and MEMRD hold while mem_ready=0.
  - While holding, PCWrite, IRWrite and RegWrite are 0.
  - MEMWR holds with MemWrite asserted until mem_ready=1.
  - The state advances in the cycle mem_ready=1; the FETCH enables pulse only in that cycle.
- Undefined: mem_ready is ignored; timing is as above.

Test Plan:
- Reset held 3 cycles then released → State=0, Flags=0, all write enables 0 during reset; PCWrite=IRWrite=1 on first FETCH.
- Instr=0xE2821005 (ADD R1,R2,#5) → states 0,1,7,8; RegWrite=1 only in ALUWB; ALUControl=0000; Flags unchanged.
- Instr=0xE5903004 (LDR R3,[R0,#4]) → states 0,1,2,3,4; AdrSrc=1 in MEMRD; ResultSrc=01 and RegWrite=1 in MEMWB.
- Instr=0xE5803004 (STR) → states 0,1,2,5; MemWrite=1 exactly one cycle.
- Instr=0xE2500001 (SUBS R0,R0,#1) with ALUFlags=4'b0110 → Flags=0110. Then 0x1AFFFFFD (BNE) → PCWrite=0 in BRANCH. Then 0x0AFFFFFD (BEQ) → PCWrite=1 in BRANCH.
- Reset asserted in MEMWR → MemWrite=0 that cycle; State=FETCH next cycle.
- With MC_MEM_WAIT_EN, mem_ready=0 for 2 cycles in FETCH → State stays 0, IRWrite=0; advances when mem_ready=1, with IRWrite=1 for exactly one cycle.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle ARM control FSM, condition unit and NZCV flags register.
// Optional MC_MEM_WAIT_EN: FETCH, MEMRD and MEMWR stall on mem_ready.
module multicycle_controller #(
  parameter logic [3:0] FLAG_RST = 4'b0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic [1:0]  ResultSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ImmSrc,
  output logic        RegWrite,
  output logic [3:0]  ALUControl,
  output logic [3:0]  Flags,
  output logic [3:0]  State
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_ORR = 4'b0011;
  localparam logic [3:0] ALU_EOR = 4'b0100;
  localparam logic [3:0] ALU_PSB = 4'b0101;

  state_t     state_q, state_d;
  logic [3:0] flags_q, flags_d;

  logic [3:0] cond;
  logic [1:0] op;
  logic       imm_i;
  logic [3:0] cmd;
  logic       u_bit;
  logic       s_bit;
  logic       l_bit;
  logic       rd_pc;

  assign cond  = Instr[31:28];
  assign op    = Instr[27:26];
  assign imm_i = Instr[25];
  assign cmd   = Instr[24:21];
  assign u_bit = Instr[23];
  assign s_bit = Instr[20];
  assign l_bit = Instr[20];
  assign rd_pc = (Instr[15:12] == 4'hf);

  logic unused_instr;
  assign unused_instr = ^{Instr[19:16], Instr[11:0]};

  logic mem_ok;
`ifdef MC_MEM_WAIT_EN
  assign mem_ok = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_ok = 1'b1;
`endif

  logic n_f, z_f, c_f, v_f;
  logic cond_ex;

  assign {n_f, z_f, c_f, v_f} = flags_q;

  always_comb begin
    cond_ex = 1'b0;
    unique case (cond)
      4'h0:    cond_ex = z_f;
      4'h1:    cond_ex = ~z_f;
      4'h2:    cond_ex = c_f;
      4'h3:    cond_ex = ~c_f;
      4'h4:    cond_ex = n_f;
      4'h5:    cond_ex = ~n_f;
      4'h6:    cond_ex = v_f;
      4'h7:    cond_ex = ~v_f;
      4'h8:    cond_ex = c_f & ~z_f;
      4'h9:    cond_ex = ~c_f | z_f;
      4'ha:    cond_ex = (n_f == v_f);
      4'hb:    cond_ex = (n_f != v_f);
      4'hc:    cond_ex = ~z_f & (n_f == v_f);
      4'hd:    cond_ex = z_f | (n_f != v_f);
      4'he:    cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  logic [3:0] dp_alu;
  logic       dp_known;
  logic       dp_cmp;
  logic       dp_arith;
  logic       dp_wr;

  always_comb begin
    dp_alu   = ALU_ADD;
    dp_known = 1'b1;
    dp_cmp   = 1'b0;
    dp_arith = 1'b0;
    case (cmd)
      4'b0100: begin
        dp_alu   = ALU_ADD;
        dp_arith = 1'b1;
      end
      4'b0010: begin
        dp_alu   = ALU_SUB;
        dp_arith = 1'b1;
      end
      4'b0000: dp_alu = ALU_AND;
      4'b1100: dp_alu = ALU_ORR;
      4'b0001: dp_alu = ALU_EOR;
      4'b1010: begin
        dp_alu   = ALU_SUB;
        dp_arith = 1'b1;
        dp_cmp   = 1'b1;
      end
      4'b1101: dp_alu = ALU_PSB;
      default: dp_known = 1'b0;
    endcase
  end

  // CMP and unknown opcodes compute but never retire a result
  assign dp_wr = cond_ex & dp_known & ~dp_cmp;

  logic pc_w, ir_w, mem_w, reg_w;

  always_comb begin
    state_d    = state_q;
    flags_d    = flags_q;
    pc_w       = 1'b0;
    ir_w       = 1'b0;
    mem_w      = 1'b0;
    reg_w      = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ImmSrc     = 2'b00;
    ALUControl = ALU_ADD;
    unique case (state_q)
      FETCH: begin
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        ir_w      = mem_ok;
        pc_w      = mem_ok;
        if (mem_ok) state_d = DECODE;
      end
      DECODE: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        unique case (op)
          2'b01:   state_d = MEMADR;
          2'b00:   state_d = imm_i ? EXECI : EXECR;
          2'b10:   state_d = BRANCH;
          default: state_d = FETCH;
        endcase
      end
      MEMADR: begin
        ALUSrcB    = 2'b01;
        ImmSrc     = 2'b01;
        ALUControl = u_bit ? ALU_ADD : ALU_SUB;
        state_d    = l_bit ? MEMRD : MEMWR;
      end
      MEMRD: begin
        AdrSrc = 1'b1;
        if (mem_ok) state_d = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        pc_w      = cond_ex & rd_pc;
        reg_w     = cond_ex & ~rd_pc;
        state_d   = FETCH;
      end
      MEMWR: begin
        AdrSrc = 1'b1;
        mem_w  = cond_ex;
        if (mem_ok) state_d = FETCH;
      end
      EXECR, EXECI: begin
        ALUSrcB    = (state_q == EXECI) ? 2'b01 : 2'b00;
        ALUControl = dp_alu;
        state_d    = ALUWB;
        if ((s_bit | dp_cmp) & cond_ex) begin
          flags_d[3:2] = ALUFlags[3:2];
          if (dp_arith) flags_d[1:0] = ALUFlags[1:0];
        end
      end
      ALUWB: begin
        ResultSrc = 2'b00;
        pc_w      = dp_wr & rd_pc;
        reg_w     = dp_wr & ~rd_pc;
        state_d   = FETCH;
      end
      BRANCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b01;
        ImmSrc    = 2'b10;
        ResultSrc = 2'b10;
        pc_w      = cond_ex;
        state_d   = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      flags_q <= FLAG_RST;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end

  assign RegSrc   = {(op == 2'b01) & ~l_bit, (op == 2'b10)};
  assign PCWrite  = pc_w & ~reset;
  assign IRWrite  = ir_w & ~reset;
  assign MemWrite = mem_w & ~reset;
  assign RegWrite = reg_w & ~reset;
  assign Flags    = flags_q;
  assign State    = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed instruction table, reset and
// wait corner sequences, and random instructions against a cycle model.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] Instr = 32'h0;
  logic [3:0]  ALUFlags = 4'h0;
  logic        mem_ready = 1'b1;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite;
  logic [1:0]  ResultSrc, ALUSrcB, RegSrc, ImmSrc;
  logic [3:0]  ALUControl, Flags, State;

  multicycle_controller #(.FLAG_RST(4'b0000)) dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegSrc(RegSrc),
    .ImmSrc(ImmSrc), .RegWrite(RegWrite), .ALUControl(ALUControl),
    .Flags(Flags), .State(State)
  );

  always #5 clk = ~clk;

`ifdef MC_MEM_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  localparam int F = 0, D = 1, MA = 2, MR = 3, MWB = 4;
  localparam int MWR = 5, ER = 6, EI = 7, AW = 8, BR = 9;

  int checks = 0;
  int errors = 0;
  logic [3:0] mflags = 4'h0;
  int n_pcw, n_irw, n_mw, n_rw, n_cyc;
  logic rdy_q[$];
  int seq[$];

  typedef struct {
    logic [31:0] ins;
    logic [3:0]  af;
    int          cyc;
    int          pcw;
    int          rw;
    int          mw;
    logic [3:0]  flags;
  } vec_t;

  vec_t tbl[18];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'ha: return n == v;
      4'hb: return n != v;
      4'hc: return !z && (n == v);
      4'hd: return z || (n != v);
      4'he: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit listed(input logic [3:0] c);
    return c inside {4'b0100, 4'b0010, 4'b0000, 4'b1100,
                     4'b0001, 4'b1010, 4'b1101};
  endfunction

  function automatic logic [3:0] dp_op(input logic [3:0] c);
    case (c)
      4'b0010, 4'b1010: return 4'd1;
      4'b0000: return 4'd2;
      4'b1100: return 4'd3;
      4'b0001: return 4'd4;
      4'b1101: return 4'd5;
      default: return 4'd0;
    endcase
  endfunction

  function void build_seq(input logic [31:0] ins);
    seq = {};
    seq.push_back(F);
    seq.push_back(D);
    case (ins[27:26])
      2'b01: begin
        seq.push_back(MA);
        if (ins[20]) begin
          seq.push_back(MR);
          seq.push_back(MWB);
        end else seq.push_back(MWR);
      end
      2'b00: begin
        seq.push_back(ins[25] ? EI : ER);
        seq.push_back(AW);
      end
      2'b10: seq.push_back(BR);
      default: ;
    endcase
  endfunction

  function automatic void expect_cycle(
      input int st, input logic [31:0] ins, input logic [3:0] f,
      input bit go, output logic [25:0] val, output logic [25:0] msk);
    bit ce, rd15, w;
    logic pcw, irw, mw, rw, adr, srca;
    logic [1:0] res, srcb, imm, rsrc;
    logic [3:0] alu;
    bit madr, mres, msrca, msrcb, mimm, malu, mrsrc;
    ce = cond_ok(ins[31:28], f);
    rd15 = (ins[15:12] == 4'hf);
    {pcw, irw, mw, rw, adr, srca} = '0;
    {res, srcb, imm, rsrc, alu} = '0;
    {madr, mres, msrca, msrcb, mimm, malu, mrsrc} = '0;
    case (st)
      F: begin
        pcw = go; irw = go; adr = 1'b0; madr = 1'b1;
        srca = 1'b1; srcb = 2'b10; alu = 4'd0; res = 2'b10;
        {msrca, msrcb, malu, mres} = 4'hf;
      end
      D: begin
        srca = 1'b1; srcb = 2'b10; alu = 4'd0;
        rsrc = {ins[27:26] == 2'b01 && !ins[20], ins[27:26] == 2'b10};
        {msrca, msrcb, malu, mrsrc} = 4'hf;
      end
      MA: begin
        srca = 1'b0; srcb = 2'b01; imm = 2'b01;
        alu = ins[23] ? 4'd0 : 4'd1;
        {msrca, msrcb, mimm, malu} = 4'hf;
      end
      MR: begin
        adr = 1'b1; madr = 1'b1;
      end
      MWB: begin
        res = 2'b01; mres = 1'b1;
        if (rd15) pcw = ce;
        else rw = ce;
      end
      MWR: begin
        adr = 1'b1; madr = 1'b1; mw = ce;
      end
      ER, EI: begin
        srca = 1'b0; srcb = (st == EI) ? 2'b01 : 2'b00; imm = 2'b00;
        alu = dp_op(ins[24:21]);
        {msrca, msrcb, mimm, malu} = 4'hf;
      end
      AW: begin
        res = 2'b00; mres = 1'b1;
        w = ce && listed(ins[24:21]) && ins[24:21] != 4'b1010;
        if (rd15) pcw = w;
        else rw = w;
      end
      default: begin
        srca = 1'b1; srcb = 2'b01; imm = 2'b10; alu = 4'd0; res = 2'b10;
        {msrca, msrcb, mimm, malu, mres} = 5'h1f;
        pcw = ce;
      end
    endcase
    val = {st[3:0], f, pcw, irw, mw, rw, adr, res, srca, srcb, imm, alu, rsrc};
    msk = {8'hff, 4'hf, madr, {2{mres}}, msrca, {2{msrcb}}, {2{mimm}},
           {4{malu}}, {2{mrsrc}}};
  endfunction

  // Entered and left at posedge+1
  task automatic run_instr(input logic [31:0] ins, input bit rand_af,
                           input logic [3:0] af, input bit rand_rdy,
                           input int abort_at);
    int i, holds, cyc, st;
    logic rdy;
    bit go;
    logic [3:0] af_now;
    logic [25:0] ev, em, av;
    build_seq(ins);
    n_pcw = 0; n_irw = 0; n_mw = 0; n_rw = 0; n_cyc = 0;
    i = 0; holds = 0; cyc = 0;
    while (i < seq.size()) begin
      st = seq[i];
      rdy = 1'b1;
      if (rdy_q.size() > 0) rdy = rdy_q.pop_front();
      else if (rand_rdy) rdy = ($urandom_range(0, 3) != 0);
      if (holds >= 6) rdy = 1'b1;
      af_now = rand_af ? 4'($urandom) : af;
      Instr = ins;
      mem_ready = rdy;
      ALUFlags = af_now;
      reset = (cyc == abort_at);
      @(negedge clk);
      if (reset) begin
        check("abort_we", {PCWrite, IRWrite, MemWrite, RegWrite}, 0);
        check("abort_state", State, st);
        @(posedge clk);
        #1;
        reset = 1'b0;
        mflags = 4'h0;
        check("post_reset", {State, Flags}, 0);
        break;
      end
      go = !WAIT_EN || rdy || !(st == F || st == MR || st == MWR);
      expect_cycle(st, ins, mflags, go, ev, em);
      av = {State, Flags, PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc,
            ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, RegSrc};
      check("cycle", av & em, ev & em);
      n_pcw += int'(PCWrite);
      n_irw += int'(IRWrite);
      n_mw += int'(MemWrite);
      n_rw += int'(RegWrite);
      if (State != 4'd0) n_cyc++;
      @(posedge clk);
      #1;
      if ((st == ER || st == EI) && (ins[20] || ins[24:21] == 4'b1010) &&
          cond_ok(ins[31:28], mflags)) begin
        mflags[3:2] = af_now[3:2];
        if (ins[24:21] inside {4'b0100, 4'b0010, 4'b1010})
          mflags[1:0] = af_now[1:0];
      end
      if (go) begin
        i++;
        holds = 0;
      end else holds++;
      cyc++;
    end
  endtask

  initial begin
    logic [31:0] rins;
    int ab;
    tbl[0]  = '{32'hE2821005, 4'hf, 4, 1, 1, 0, 4'h0};
    tbl[1]  = '{32'hE5903004, 4'hf, 5, 1, 1, 0, 4'h0};
    tbl[2]  = '{32'hE5803004, 4'hf, 4, 1, 0, 1, 4'h0};
    tbl[3]  = '{32'hE2500001, 4'h6, 4, 1, 1, 0, 4'h6};
    tbl[4]  = '{32'h1AFFFFFD, 4'h0, 3, 1, 0, 0, 4'h6};
    tbl[5]  = '{32'h0AFFFFFD, 4'h0, 3, 2, 0, 0, 4'h6};
    tbl[6]  = '{32'hE3A0F000, 4'h0, 4, 2, 0, 0, 4'h6};
    tbl[7]  = '{32'hE1500001, 4'h9, 4, 1, 0, 0, 4'h9};
    tbl[8]  = '{32'hE0810002, 4'h0, 4, 1, 1, 0, 4'h9};
    tbl[9]  = '{32'hF2821005, 4'h0, 4, 1, 0, 0, 4'h9};
    tbl[10] = '{32'hE3F00000, 4'h7, 4, 1, 0, 0, 4'h5};
    tbl[11] = '{32'hEC000000, 4'h0, 2, 1, 0, 0, 4'h5};
    tbl[12] = '{32'hE2111000, 4'ha, 4, 1, 1, 0, 4'h9};
    tbl[13] = '{32'hE590F000, 4'h0, 5, 2, 0, 0, 4'h9};
    tbl[14] = '{32'hB5003004, 4'h0, 4, 1, 0, 0, 4'h9};
    tbl[15] = '{32'hA5003004, 4'h0, 4, 1, 0, 1, 4'h9};
    tbl[16] = '{32'hE2911001, 4'h3, 4, 1, 1, 0, 4'h3};
    tbl[17] = '{32'h02500001, 4'hf, 4, 1, 0, 0, 4'h3};

    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_we", {PCWrite, IRWrite, MemWrite, RegWrite}, 0);
      check("rst_state", {State, Flags}, 0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    mflags = 4'h0;

    for (int k = 0; k < 18; k++) begin
      run_instr(tbl[k].ins, 1'b0, tbl[k].af, 1'b0, -1);
      check($sformatf("tbl%0d_cyc", k), n_cyc + 1, tbl[k].cyc);
      check($sformatf("tbl%0d_pcw", k), n_pcw, tbl[k].pcw);
      check($sformatf("tbl%0d_rw", k), n_rw, tbl[k].rw);
      check($sformatf("tbl%0d_mw", k), n_mw, tbl[k].mw);
      check($sformatf("tbl%0d_flags", k), Flags, tbl[k].flags);
    end

    run_instr(32'hE5803004, 1'b0, 4'h0, 1'b0, 3);
    run_instr(32'hE2821005, 1'b0, 4'h0, 1'b0, -1);
    check("after_abort_rw", n_rw, 1);
    run_instr(32'hE2500001, 1'b0, 4'hf, 1'b0, 2);
    check("abort_exec_flags", Flags, 4'h0);

    rdy_q.push_back(1'b0);
    rdy_q.push_back(1'b0);
    run_instr(32'hE2821005, 1'b0, 4'h0, 1'b0, -1);
    check("wait_irw", n_irw, 1);
    check("wait_pcw", n_pcw, 1);
    rdy_q = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    run_instr(32'hE5803004, 1'b0, 4'h0, 1'b0, -1);
    check("wait_mw", n_mw, WAIT_EN ? 3 : 1);
    rdy_q = '{1'b1, 1'b1, 1'b1, 1'b0};
    run_instr(32'hE5903004, 1'b0, 4'h0, 1'b0, -1);
    check("wait_ldr_rw", n_rw, 1);

    for (int k = 0; k < 400; k++) begin
      rins = $urandom;
      if ($urandom_range(0, 2) != 0) rins[31:28] = 4'he;
      if ($urandom_range(0, 3) == 0) rins[15:12] = 4'hf;
      ab = ($urandom_range(0, 29) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_instr(rins, 1'b1, 4'h0, 1'b1, ab);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
